// File: rtl/dequantizer_pkg.sv
// Shared constants for the JPEG decoder dequantizer: block geometry, zig-zag order,
// Annex K quantization tables (natural order) and the read-side state encoding.
package dequantizer_pkg;

    localparam int BLOCK_COEFS = 64;
    localparam int BLOCK_ROWS  = 8;
    localparam int QTAB_WIDTH  = 8;

    typedef enum logic {IDLE, SEND} rd_state_t;

    localparam logic [5:0] ZIGZAG_TO_NATURAL [BLOCK_COEFS] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    localparam logic [QTAB_WIDTH-1:0] LUMA_QTABLE [BLOCK_COEFS] = '{
        16, 11, 10, 16,  24,  40,  51,  61,
        12, 12, 14, 19,  26,  58,  60,  55,
        14, 13, 16, 24,  40,  57,  69,  56,
        14, 17, 22, 29,  51,  87,  80,  62,
        18, 22, 37, 56,  68, 109, 103,  77,
        24, 35, 55, 64,  81, 104, 113,  92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103,  99
    };

    localparam logic [QTAB_WIDTH-1:0] CHROMA_QTABLE [BLOCK_COEFS] = '{
        17, 18, 24, 47, 99, 99, 99, 99,
        18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,
        47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99
    };

endpackage

// File: rtl/dequantizer_if.sv
// Coefficient-in / row-out handshake bundle of the dequantizer.
// slave is the dequantizer side, master is the producer/consumer environment.
interface dequantizer_if #(
    parameter int IN_WIDTH  = 11,
    parameter int OUT_WIDTH = 14
);
    logic                        I_yc;
    logic                        I_coef_valid;
    logic signed [IN_WIDTH-1:0]  I_coef;
    logic                        O_coef_ready;
    logic                        O_row_valid;
    logic                        I_row_ready;
    logic signed [OUT_WIDTH-1:0] O_idct_0;
    logic signed [OUT_WIDTH-1:0] O_idct_1;
    logic signed [OUT_WIDTH-1:0] O_idct_2;
    logic signed [OUT_WIDTH-1:0] O_idct_3;
    logic signed [OUT_WIDTH-1:0] O_idct_4;
    logic signed [OUT_WIDTH-1:0] O_idct_5;
    logic signed [OUT_WIDTH-1:0] O_idct_6;
    logic signed [OUT_WIDTH-1:0] O_idct_7;
    logic [2:0]                  O_row_index;
    logic                        O_block_last;

    modport slave (
        input  I_yc, I_coef_valid, I_coef, I_row_ready,
        output O_coef_ready, O_row_valid, O_row_index, O_block_last,
        output O_idct_0, O_idct_1, O_idct_2, O_idct_3,
        output O_idct_4, O_idct_5, O_idct_6, O_idct_7
    );

    modport master (
        output I_yc, I_coef_valid, I_coef, I_row_ready,
        input  O_coef_ready, O_row_valid, O_row_index, O_block_last,
        input  O_idct_0, O_idct_1, O_idct_2, O_idct_3,
        input  O_idct_4, O_idct_5, O_idct_6, O_idct_7
    );
endinterface

// File: rtl/dequantizer_zigzag_rom.sv
// Combinational zig-zag index k to natural (row*8+col) address lookup.
module dequantizer_zigzag_rom
    import dequantizer_pkg::*;
(
    input  logic [5:0] k,
    output logic [5:0] n
);
    assign n = ZIGZAG_TO_NATURAL[k];
endmodule

// File: rtl/dequantizer.sv
// Dequantizer: zig-zag coefficients in, multiplied by the JPEG table entry, written
// de-zig-zagged into a ping-pong block buffer and streamed out as 8-wide rows.
module dequantizer
    import dequantizer_pkg::*;
#(
    parameter int IN_WIDTH  = 11,
    parameter int OUT_WIDTH = 14,
    parameter int Q_WIDTH   = 8
) (
    input  logic         I_clk,
    input  logic         I_rst,
    input  logic         I_en,
    dequantizer_if.slave bus
);

    localparam int P_WIDTH = IN_WIDTH + Q_WIDTH + 1;
    localparam logic signed [P_WIDTH-1:0] SAT_MAX =
        {{(P_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [P_WIDTH-1:0] SAT_MIN =
        {{(P_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [5:0] K_LAST   = 6'(BLOCK_COEFS - 1);
    localparam logic [2:0] ROW_LAST = 3'(BLOCK_ROWS - 1);

    logic [5:0] k_reg;
    logic       wb_reg;
    logic       yc_blk_reg;
    logic [1:0] full_reg;
    logic       coef_ready;
    logic       accept;
    logic       yc_sel;
    logic [5:0] nat_addr;

    logic                       s1_valid_reg;
    logic signed [IN_WIDTH-1:0] s1_coef_reg;
    logic [5:0]                 s1_n_reg;
    logic                       s1_bank_reg;
    logic                       s1_last_reg;
    logic [Q_WIDTH-1:0]         s1_q_reg;

    logic                        s2_valid_reg;
    logic signed [OUT_WIDTH-1:0] s2_data_reg;
    logic [5:0]                  s2_n_reg;
    logic                        s2_bank_reg;
    logic                        s2_last_reg;

    logic signed [P_WIDTH-1:0]   coef_ext;
    logic signed [P_WIDTH-1:0]   q_ext;
    logic signed [P_WIDTH-1:0]   product;
    logic signed [OUT_WIDTH-1:0] product_sat;

    logic signed [OUT_WIDTH-1:0] mem_reg [2*BLOCK_COEFS];

    rd_state_t  state_reg, state_next;
    logic       rb_reg, rb_next;
    logic       row_valid_reg, row_valid_next;
    logic [2:0] row_idx_reg, row_idx_next;
    logic       load;
    logic       load_bank;
    logic [2:0] load_row;
    logic       clr_full;
    logic       row_xfer;
    logic signed [OUT_WIDTH-1:0] idct_col [BLOCK_ROWS];

    assign coef_ready = !full_reg[wb_reg];
    assign accept     = bus.I_coef_valid && coef_ready && I_en;
    // Table select is taken live at k=0 and then held for the rest of the block.
    assign yc_sel     = (k_reg == 6'd0) ? bus.I_yc : yc_blk_reg;

    dequantizer_zigzag_rom u_zigzag (
        .k (k_reg),
        .n (nat_addr)
    );

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            k_reg        <= '0;
            wb_reg       <= 1'b0;
            yc_blk_reg   <= 1'b0;
            s1_valid_reg <= 1'b0;
            s1_coef_reg  <= '0;
            s1_n_reg     <= '0;
            s1_bank_reg  <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_q_reg     <= '0;
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
            s2_n_reg     <= '0;
            s2_bank_reg  <= 1'b0;
            s2_last_reg  <= 1'b0;
        end else if (I_en) begin
            if (accept) begin
                k_reg <= k_reg + 6'd1;
                if (k_reg == K_LAST) wb_reg <= ~wb_reg;
                if (k_reg == 6'd0)   yc_blk_reg <= bus.I_yc;
            end
            s1_valid_reg <= accept;
            s1_coef_reg  <= bus.I_coef;
            s1_n_reg     <= nat_addr;
            s1_bank_reg  <= wb_reg;
            s1_last_reg  <= (k_reg == K_LAST);
            case (yc_sel)
                1'b0:    s1_q_reg <= LUMA_QTABLE[nat_addr];
                default: s1_q_reg <= CHROMA_QTABLE[nat_addr];
            endcase
            s2_valid_reg <= s1_valid_reg;
            s2_data_reg  <= product_sat;
            s2_n_reg     <= s1_n_reg;
            s2_bank_reg  <= s1_bank_reg;
            s2_last_reg  <= s1_last_reg;
        end
    end

    // Exact integer multiply at full width, then clip into the IDCT input range.
    always_comb begin
        coef_ext = {{(P_WIDTH-IN_WIDTH){s1_coef_reg[IN_WIDTH-1]}}, s1_coef_reg};
        q_ext    = {{(P_WIDTH-Q_WIDTH){1'b0}}, s1_q_reg};
        product  = coef_ext * q_ext;
        if (product > SAT_MAX)
            product_sat = SAT_MAX[OUT_WIDTH-1:0];
        else if (product < SAT_MIN)
            product_sat = SAT_MIN[OUT_WIDTH-1:0];
        else
            product_sat = product[OUT_WIDTH-1:0];
    end

    always_ff @(posedge I_clk) begin
        if (I_en && s2_valid_reg)
            mem_reg[{s2_bank_reg, s2_n_reg}] <= s2_data_reg;
    end

    // Set and clear always target different banks, so both may happen on one edge.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            full_reg <= '0;
        end else if (I_en) begin
            for (int b = 0; b < 2; b++) begin
                if (s2_valid_reg && s2_last_reg && (s2_bank_reg == b[0]))
                    full_reg[b] <= 1'b1;
                else if (clr_full && (rb_reg == b[0]))
                    full_reg[b] <= 1'b0;
            end
        end
    end

    assign row_xfer = row_valid_reg && bus.I_row_ready && I_en;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_reg     <= IDLE;
            rb_reg        <= 1'b0;
            row_valid_reg <= 1'b0;
            row_idx_reg   <= '0;
        end else if (I_en) begin
            state_reg     <= state_next;
            rb_reg        <= rb_next;
            row_valid_reg <= row_valid_next;
            row_idx_reg   <= row_idx_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rb_next        = rb_reg;
        row_valid_next = row_valid_reg;
        row_idx_next   = row_idx_reg;
        load           = 1'b0;
        load_bank      = rb_reg;
        load_row       = '0;
        clr_full       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (full_reg[rb_reg]) begin
                    load           = 1'b1;
                    row_valid_next = 1'b1;
                    row_idx_next   = '0;
                    state_next     = SEND;
                end
            end
            default: begin
                if (row_xfer) begin
                    if (row_idx_reg != ROW_LAST) begin
                        load         = 1'b1;
                        load_row     = row_idx_reg + 3'd1;
                        row_idx_next = row_idx_reg + 3'd1;
                    end else begin
                        clr_full = 1'b1;
                        rb_next  = ~rb_reg;
                        // Other bank already complete: chain straight into its row 0.
                        if (full_reg[~rb_reg]) begin
                            load         = 1'b1;
                            load_bank    = ~rb_reg;
                            row_idx_next = '0;
                        end else begin
                            row_valid_next = 1'b0;
                            state_next     = IDLE;
                        end
                    end
                end
            end
        endcase
    end

    for (genvar gi = 0; gi < BLOCK_ROWS; gi++) begin : g_col
        logic signed [OUT_WIDTH-1:0] col_reg;
        always_ff @(posedge I_clk) begin
            if (I_rst)
                col_reg <= '0;
            else if (I_en && load)
                col_reg <= mem_reg[{load_bank, load_row, 3'(gi)}];
        end
        assign idct_col[gi] = col_reg;
    end

    always_comb begin
        bus.O_row_valid  = row_valid_reg;
        bus.O_row_index  = row_idx_reg;
        bus.O_block_last = row_valid_reg && (row_idx_reg == ROW_LAST);
    end

    assign bus.O_coef_ready = coef_ready;
    assign bus.O_idct_0     = idct_col[0];
    assign bus.O_idct_1     = idct_col[1];
    assign bus.O_idct_2     = idct_col[2];
    assign bus.O_idct_3     = idct_col[3];
    assign bus.O_idct_4     = idct_col[4];
    assign bus.O_idct_5     = idct_col[5];
    assign bus.O_idct_6     = idct_col[6];
    assign bus.O_idct_7     = idct_col[7];

endmodule
